// File: rtl/rv32_pkg.sv
// ============================================================================
// Module  : rv32_pkg
// Purpose : Shared RV32 widths, NOP encoding and fetch FSM state type.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_pkg;

  localparam int XLEN     = 32;
  localparam int OPCODE_W = 7;
  localparam int FUNCT3_W = 3;
  localparam int FUNCT7_W = 7;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_pc_next.sv
// ============================================================================
// Module  : pc_next
// Purpose : Next fetch address (sequential or redirect) plus misalign flag.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign
);

  always_comb begin
    next_pc  = redirect ? redirect_target : (pc + 32'd4);
    misalign = |next_pc[1:0];
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module  : fetch_unit
// Purpose : Single-outstanding instruction fetch stage with decode handshake.
//           Optional FETCH_MISALIGN_CHECK_EN adds a sticky fetch_err output.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [rv32_pkg::XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [rv32_pkg::XLEN-1:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_req,
  output logic [rv32_pkg::XLEN-1:0]     imem_addr,
  input  logic                          imem_gnt,
  input  logic                          imem_rvalid,
  input  logic [rv32_pkg::XLEN-1:0]     imem_rdata,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [rv32_pkg::XLEN-1:0]     instr,
  output logic [rv32_pkg::XLEN-1:0]     pc,
  output logic [rv32_pkg::OPCODE_W-1:0] OP,
  output logic [rv32_pkg::FUNCT3_W-1:0] funct3,
  output logic [rv32_pkg::FUNCT7_W-1:0] funct7,
  input  logic                          redirect,
  input  logic [rv32_pkg::XLEN-1:0]     redirect_target
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                          fetch_err
`endif
);

  import rv32_pkg::XLEN;
  import rv32_pkg::fetch_state_e;
  import rv32_pkg::ST_IDLE;
  import rv32_pkg::ST_REQ;
  import rv32_pkg::ST_WAIT;
  import rv32_pkg::ST_HOLD;

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_next_fetch;
  logic            w_misalign;
  logic            w_err;
  logic            w_fault;
  logic            w_consume;
  logic            w_advance;
  logic            w_capture;

  pc_next u_pc_next (
    .pc              (r_pc),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .next_pc         (w_next_pc),
    .misalign        (w_misalign)
  );

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_consume && w_misalign) begin
      r_err <= 1'b1;
    end
  end

  assign w_err        = r_err;
  assign w_fault      = w_misalign;
  assign w_next_fetch = w_next_pc;
  assign fetch_err    = r_err;
`else
  assign w_err        = 1'b0;
  assign w_fault      = 1'b0;
  // Without the checker, low address bits are simply dropped.
  assign w_next_fetch = w_misalign ? {w_next_pc[XLEN-1:2], 2'b00} : w_next_pc;
`endif

  // Once faulted the unit parks in HOLD and ignores the decode handshake.
  assign w_consume = (r_state == ST_HOLD) && instr_ready && !w_err;
  assign w_advance = w_consume && !w_fault;
  assign w_capture = (r_state == ST_WAIT) && imem_rvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_REQ;
      ST_REQ:  if (imem_gnt)  w_state_nxt = ST_WAIT;
      ST_WAIT: if (w_capture) w_state_nxt = ST_HOLD;
      ST_HOLD: if (w_advance) w_state_nxt = ST_REQ;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (r_state)
      ST_REQ:  imem_req    = 1'b1;
      ST_HOLD: instr_valid = !w_err;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_pc       <= RESET_PC;
      r_instr    <= NOP_INSTR;
    end else begin
      if (w_advance) begin
        r_fetch_pc <= w_next_fetch;
      end
      if (w_capture) begin
        r_pc    <= r_fetch_pc;
        r_instr <= imem_rdata;
      end
    end
  end

  assign imem_addr = r_fetch_pc;
  assign pc        = r_pc;
  assign instr     = instr_valid ? r_instr : NOP_INSTR;
  assign OP        = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module  : tb_fetch_unit
// Purpose : Directed + randomized self-checking bench for fetch_unit.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [6:0]  OP;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model_pc;
  logic [31:0] exp_word;
  bit          pending;
  bit          expect_hold;
  int          delay;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .pc              (pc),
    .OP              (OP),
    .funct3          (funct3),
    .funct7          (funct7),
    .redirect        (redirect),
    .redirect_target (redirect_target)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_err       (fetch_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic rd,
                                             input logic [31:0] tgt);
    logic [31:0] n;
    n = rd ? tgt : cur + 32'd4;
`ifndef FETCH_MISALIGN_CHECK_EN
    n[1:0] = 2'b00;
`endif
    return n;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   {31'b0, imem_req},    32'd0);
    check_eq({tag, "_addr"},  imem_addr,            RST_PC);
    check_eq({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    check_eq({tag, "_instr"}, instr,                NOP);
    check_eq({tag, "_pc"},    pc,                   RST_PC);
`ifdef FETCH_MISALIGN_CHECK_EN
    check_eq({tag, "_err"},   {31'b0, fetch_err},   32'd0);
`endif
  endtask

  task automatic check_held(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
    check_eq({tag, "_valid"},  {31'b0, instr_valid}, 32'd1);
    check_eq({tag, "_pc"},     pc,                   exp_pc);
    check_eq({tag, "_instr"},  instr,                exp_instr);
    check_eq({tag, "_op"},     {25'b0, OP},          {25'b0, exp_instr[6:0]});
    check_eq({tag, "_funct3"}, {29'b0, funct3},      {29'b0, exp_instr[14:12]});
    check_eq({tag, "_funct7"}, {25'b0, funct7},      {25'b0, exp_instr[31:25]});
    check_eq({tag, "_req"},    {31'b0, imem_req},    32'd0);
  endtask

  initial begin
    repeat (2) step();
    check_reset_outputs("reset");

    // First fetch at minimum latency.
    rst = 1'b0;
    step();
    check_eq("first_req",  {31'b0, imem_req}, 32'd1);
    check_eq("first_addr", imem_addr,         RST_PC);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    check_eq("first_wait_req",   {31'b0, imem_req},    32'd0);
    check_eq("first_wait_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("first_wait_instr", instr,                NOP);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    step();
    imem_rvalid = 1'b0;
    check_held("first_hold", 32'h0, 32'h0050_0093);
    check_eq("first_op", {25'b0, OP}, 32'h13);

    // Decode stall.
    for (int i = 0; i < 5; i++) begin
      imem_rdata = $urandom;
      step();
      check_held("stall", 32'h0, 32'h0050_0093);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check_eq("seq_req",  {31'b0, imem_req}, 32'd1);
    check_eq("seq_addr", imem_addr,         32'h4);

    // Grant withheld, stray rvalid while requesting.
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("nogrant_req",   {31'b0, imem_req},    32'd1);
      check_eq("nogrant_addr",  imem_addr,            32'h4);
      check_eq("nogrant_valid", {31'b0, instr_valid}, 32'd0);
    end
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(32'h4);
    step();
    imem_rvalid = 1'b0;
    check_held("pc4", 32'h4, mem_word(32'h4));
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check_eq("pc8_addr", imem_addr, 32'h8);
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(32'h8);
    step();
    imem_rvalid = 1'b0;
    check_held("pc8", 32'h8, mem_word(32'h8));

    // Redirect only honoured together with ready.
    redirect        = 1'b1;
    redirect_target = 32'h40;
    step();
    check_held("redir_noready", 32'h8, mem_word(32'h8));
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    redirect    = 1'b0;
    check_eq("redir_req",  {31'b0, imem_req}, 32'd1);
    check_eq("redir_addr", imem_addr,         32'h40);

    // Reset while waiting for data, then a stale rvalid.
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    check_eq("wait_req", {31'b0, imem_req}, 32'd0);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_wait");
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0000;
    step();
    rst = 1'b0;
    step();
    check_eq("post_rst_req",  {31'b0, imem_req},    32'd1);
    check_eq("post_rst_addr", imem_addr,            RST_PC);
    step();
    imem_rvalid = 1'b0;
    check_eq("stale_req",   {31'b0, imem_req},    32'd1);
    check_eq("stale_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("stale_instr", instr,                NOP);

    // Randomized traffic against a transaction-level model.
    model_pc    = RST_PC;
    pending     = 1'b0;
    expect_hold = 1'b0;
    delay       = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      exp_word = mem_word(model_pc);
      check_eq("rnd_valid", {31'b0, instr_valid}, {31'b0, expect_hold});
      check_eq("rnd_req",   {31'b0, imem_req},    {31'b0, !expect_hold && !pending});
      if (expect_hold) begin
        check_eq("rnd_pc",    pc,    model_pc);
        check_eq("rnd_instr", instr, exp_word);
        check_eq("rnd_f3",    {29'b0, funct3}, {29'b0, exp_word[14:12]});
      end else begin
        check_eq("rnd_nop", instr, NOP);
        if (!pending) check_eq("rnd_addr", imem_addr, model_pc);
      end

      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      instr_ready = 1'b0;
      redirect    = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_target = 32'hFFFF_FFF8;
        1:       redirect_target = 32'hFFFF_FFFC;
        default: redirect_target = $urandom;
      endcase
`ifdef FETCH_MISALIGN_CHECK_EN
      redirect_target[1:0] = 2'b00;
`endif

      if (expect_hold) begin
        instr_ready = ($urandom_range(0, 1) == 1);
        imem_rvalid = ($urandom_range(0, 3) == 0);
        imem_gnt    = ($urandom_range(0, 1) == 1);
        if (instr_ready) begin
          model_pc    = model_next(model_pc, redirect, redirect_target);
          expect_hold = 1'b0;
        end
      end else if (pending) begin
        imem_gnt = ($urandom_range(0, 1) == 1);
        if (delay == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = exp_word;
          pending     = 1'b0;
          expect_hold = 1'b1;
        end else begin
          delay--;
        end
      end else begin
        imem_gnt    = ($urandom_range(0, 2) != 0);
        imem_rvalid = ($urandom_range(0, 3) == 0);
        if (imem_gnt) begin
          pending = 1'b1;
          delay   = $urandom_range(0, 2);
        end
      end
      step();
    end
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect parks the unit with a sticky error.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(RST_PC);
    step();
    imem_rvalid = 1'b0;
    check_held("mis_hold", RST_PC, mem_word(RST_PC));
    redirect        = 1'b1;
    redirect_target = 32'h42;
    instr_ready     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      imem_gnt = 1'b1;
      check_eq("mis_err",   {31'b0, fetch_err},   32'd1);
      check_eq("mis_req",   {31'b0, imem_req},    32'd0);
      check_eq("mis_valid", {31'b0, instr_valid}, 32'd0);
    end
    imem_gnt    = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): instruction value held while no instruction is valid.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  byte address of the request.
REQ-007 imem_gnt  input  1  memory accepted the request this cycle.
REQ-008 imem_rvalid  input  1  imem_rdata valid this cycle.
REQ-009 imem_rdata  input  32  returned instruction word.
REQ-010 instr_valid  output  1  instr/pc/OP/funct3/funct7 valid for the decode stage.
REQ-011 instr_ready  input  1  decode/execute consumes the held instruction this cycle.
REQ-012 instr  output  32  held instruction; pc  output  32  its address.
REQ-013 OP  output  7  instr[6:0]; funct3  output  3  instr[14:12]; funct7  output  7  instr[31:25]; these feed the control unit directly.
REQ-014 redirect  input  1  taken branch or jump of the held instruction; redirect_target  input  32  new PC.

Function
REQ-015 FSM states IDLE, REQ, WAIT, HOLD; IDLE -> REQ unconditionally on the first edge after rst deasserts.
REQ-016 REQ: imem_req=1, imem_addr=fetch_pc; imem_gnt=1 -> WAIT, otherwise remain in REQ with address stable.
REQ-017 WAIT: imem_req=0; imem_rvalid=1 -> latch imem_rdata into instr, latch fetch_pc into pc, -> HOLD.
REQ-018 instr_valid=1 exactly while in HOLD; instr, pc, OP, funct3, funct7 stable throughout HOLD.
REQ-019 HOLD with instr_ready=0: remain in HOLD, no memory request.
REQ-020 HOLD with instr_ready=1: fetch_pc <= redirect ? redirect_target : pc+4 (32-bit, wraps FFFF_FFFC -> 0000_0000), -> REQ.
REQ-021 redirect sampled only when state==HOLD and instr_ready=1; ignored in all other states.
REQ-022 imem_rvalid outside WAIT and imem_gnt outside REQ are ignored.
REQ-023 Minimum latency: gnt in REQ cycle, rvalid next cycle -> instr_valid on the following cycle; 3 cycles per instruction at zero-wait memory.
REQ-024 Outside HOLD, instr holds NOP_INSTR and OP/funct3/funct7 reflect NOP_INSTR.

Reset
REQ-025 rst asserted: state=IDLE, fetch_pc=RESET_PC, pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, instr=NOP_INSTR, instr_valid=0, fetch_err=0.
REQ-026 rst asserted mid-transaction (REQ/WAIT/HOLD) aborts immediately; a late imem_rvalid after reset release, arriving in IDLE or REQ, is ignored.

Configuration
REQ-027 Macro FETCH_MISALIGN_CHECK_EN defined: output fetch_err (1 bit) added; if the next fetch_pc (REQ-020) has bits[1:0]!=0, fetch_err=1 sticky until rst, FSM enters HOLD with instr_valid=0 and issues no further requests.
REQ-028 Macro undefined: no fetch_err port; fetch_pc bits[1:0] forced to 00 on update.

Structure
REQ-029 Package rv32_pkg holds: XLEN=32, opcode-field widths, NOP_INSTR constant, fetch FSM state enum typedef.
REQ-030 Sub-module pc_next (combinational: pc, redirect, redirect_target -> next fetch_pc, misalign flag) instantiated once.

Verification
REQ-031 Reset release, gnt=1 and rvalid=1 on first opportunity, rdata=0x00500093 -> instr_valid=1 at cycle 3, pc=0x0, OP=0x13, funct3=0, funct7=0.
REQ-032 Hold instr_ready=0 for 5 cycles -> instr/pc stable, imem_req=0 throughout; ready=1 -> next imem_addr=0x4.
REQ-033 Held pc=0x8, redirect=1, target=0x40, instr_ready=1 -> next imem_addr=0x40; redirect=1 with ready=0 -> no effect.
REQ-034 imem_gnt withheld 4 cycles -> imem_req=1, imem_addr constant; rvalid pulsed in REQ -> ignored.
REQ-035 rst pulsed while in WAIT -> outputs at reset values, next request to RESET_PC, stale rvalid ignored.
REQ-036 With FETCH_MISALIGN_CHECK_EN, redirect target 0x42 -> fetch_err=1, imem_req stays 0, instr_valid=0.
